llr_fmt_conv: RTL
=================

# llr_fmt_conv

Parametrised, pipelined, multi-channel LLR format converter between two's-complement (2C) and sign-magnitude (SM). It sits between the VNU arithmetic, which works in 2C, and the shuffled message memories and CNU datapath, which work in SM. It replaces the single-channel, XOR-only, combinational conversion with several changes:
- exact conversion in both directions;
- explicit saturation of the unrepresentable 2C minimum;
- valid/ready flow control;
- a saturation event counter.

## Interface
- W, 11, bits per LLR (sign + W-1 magnitude/value bits); W >= 3
- N_CH, 8, parallel channels per beat
- CNT_W, 16, width of saturation event counter
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat
- i_data  in  N_CH*W  channel c at bits [c*W +: W]
- i_mode  in  2  conversion mode, sampled with the beat
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts output
- o_data  out  N_CH*W  converted channels, same packing
- o_sat  out  N_CH  per-channel saturation flag, aligned with o_data
- o_sat_cnt  out  CNT_W  saturating count of saturated channels
- i_sat_clr  in  1  clear o_sat_cnt

## Operation
Modes (i_mode):
- **00 C2S (2C→SM, exact)**
  - x >= 0: output is x.
  - x < 0: output is {1, -x}.
  - x = -2^(W-1): output is {1, all ones}, and o_sat[c] = 1.
- **01 S2C (SM→2C, exact)**
  - Sign bit 0: output is the input.
  - Sign bit 1 with magnitude m: output is -m in 2C.
  - Negative zero ({1,0...0}): output is 0, with no flag.
- **10 LEG (legacy, one's-complement style)**
  - Output is {x[W-1], x[W-2:0] ^ {W-1{x[W-1]}}}.
  - o_sat is always 0.
- **11 BYP**: output is the input unchanged; o_sat is 0.

Mode rules:
- The mode travels with each beat, so beats in different modes may be back-to-back.
- Channels are converted independently and identically.

Saturation counter:
- On each output handshake (o_valid && i_ready), o_sat_cnt adds popcount(o_sat) and clamps at 2^CNT_W-1.
- If i_sat_clr is high in the same cycle as a handshake, the counter loads that beat's popcount. Otherwise i_sat_clr loads 0.

## Timing
Pipeline:
- Two register stages:
  - S1 registers i_data and i_mode.
  - S2 registers the converted data, o_sat and the valid bit.
- Latency is 2 cycles from input handshake to o_valid when unstalled.
- Throughput is 1 beat per cycle.

Handshake:
- Stage advance:
  - adv2 = !s2_v || i_ready
  - adv1 = !s1_v || adv2
  - o_ready = adv1 && !i_rst
- o_ready is combinational from i_ready.
- An input is accepted only on i_valid && o_ready.
- o_data and o_sat hold stable while o_valid && !i_ready.
- No beat is dropped or duplicated, and order is preserved.
- With i_ready low, the block absorbs exactly 2 beats, then o_ready = 0.

Reset:
- s1_v, s2_v and o_valid go to 0.
- o_data goes to 0, o_sat to 0, o_sat_cnt to 0.
- o_ready is 0 during reset and 1 in the first cycle after reset.
- Reset mid-stream discards all in-flight beats. The first cycle after reset behaves as empty.

Simultaneous events:
- Input accept and output handshake in the same cycle is a normal pass-through.
- Clear and increment together: see the saturation counter rule.

Arithmetic:
- Negation is computed W bits wide.
- The -2^(W-1) input is detected explicitly, not via overflow of the negation.

## Structure
- Package llr_fmt_pkg holds:
  - typedef enum logic [1:0] conv_mode_e {C2S, S2C, LEG, BYP};
  - default W, N_CH and CNT_W localparams.
- Sub-module llr_fmt_conv_ch: purely combinational single-channel converter.
  - Ports: data in, mode in, data out, sat out; parameter W.
  - Instantiated N_CH times via generate between S1 and S2.
- The top level holds the pipeline registers, handshake logic, popcount and counter.

## Test plan
Defaults W=11, N_CH=8.
- C2S on all channels: 0x7FF (-1) → 0x401; 0x005 → 0x005; 0x400 (-1024) → 0x7FF with o_sat=1. For a beat with three 0x400 channels, o_sat_cnt goes 0 → 3.
- S2C: 0x401 → 0x7FF; 0x3FF → 0x3FF; 0x400 (negative zero) → 0x000 with o_sat=0; 0x7FF → 0x401.
- LEG: 0x7FF → 0x400; 0x000 → 0x000. BYP: 0x400 → 0x400 with o_sat=0. Send alternating modes on consecutive beats; each output matches its own beat's mode.
- Backpressure:
  - Stimulus: stream beats 1..6 with i_ready held low for cycles 3–7.
  - Response: o_ready deasserts after 2 beats are buffered; o_data stays stable while stalled; outputs are 1..6 in order with no loss.
- Counter:
  - With CNT_W=3, seven saturating beats clamp o_sat_cnt at 7.
  - i_sat_clr together with a 2-saturation handshake gives 2.
  - i_sat_clr alone gives 0.
- Reset:
  - Assert i_rst with 2 beats in flight.
  - o_valid and o_sat_cnt are 0 next cycle, the in-flight beats never emerge, and o_ready is 1 the cycle after i_rst falls.

Source files
------------

// File: rtl/llr_fmt_pkg.sv
// llr_fmt_pkg: shared conversion modes and default widths for the LLR format converter
package llr_fmt_pkg;
    typedef enum logic [1:0] {C2S, S2C, LEG, BYP} conv_mode_e;
    localparam int DEF_W     = 11;
    localparam int DEF_N_CH  = 8;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/llr_fmt_conv_ch.sv
// llr_fmt_conv_ch: combinational single-channel 2C/SM/legacy converter
module llr_fmt_conv_ch
    import llr_fmt_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] i_data,
    input  conv_mode_e   i_mode,
    output logic [W-1:0] o_data,
    output logic         o_sat
);
    localparam logic [W-1:0] SIGN = {1'b1, {(W-1){1'b0}}};
    logic [W-1:0] w_neg, w_mag_neg, w_c2s, w_s2c, w_leg;
    logic         w_min;
    assign w_neg     = W'(0) - i_data;
    assign w_mag_neg = W'(0) - {1'b0, i_data[W-2:0]};
    // the 2C minimum has no SM image, so it is caught before it can alias through negation
    assign w_min     = i_data == SIGN;
    assign w_c2s     = !i_data[W-1] ? i_data : w_min ? {W{1'b1}} : (w_neg | SIGN);
    assign w_s2c     = i_data[W-1] ? w_mag_neg : i_data;
    assign w_leg     = {i_data[W-1], i_data[W-2:0] ^ {(W-1){i_data[W-1]}}};
    always_comb begin
        o_data = i_mode == C2S ? w_c2s : i_mode == S2C ? w_s2c : i_mode == LEG ? w_leg : i_data;
        o_sat  = i_mode == C2S && w_min;
    end
endmodule

// File: rtl/llr_fmt_conv.sv
// llr_fmt_conv: two-stage valid/ready multi-channel LLR format converter with saturation counter
module llr_fmt_conv
    import llr_fmt_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [N_CH*W-1:0] i_data,
    input  logic [1:0]        i_mode,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [N_CH*W-1:0] o_data,
    output logic [N_CH-1:0]   o_sat,
    output logic [CNT_W-1:0]  o_sat_cnt,
    input  logic              i_sat_clr
);
    localparam int PW = $clog2(N_CH + 1);
    localparam int SW = (CNT_W > PW ? CNT_W : PW) + 1;
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});
    logic              r_s1_v, r_s2_v;
    logic [N_CH*W-1:0] r_s1_data, r_s2_data, w_conv;
    conv_mode_e        r_s1_mode;
    logic [N_CH-1:0]   r_s2_sat, w_sat;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_adv1, w_adv2, w_hs;
    logic [PW-1:0]     w_pop;
    logic [SW-1:0]     w_sum;
    assign w_adv2    = !r_s2_v || i_ready;
    assign w_adv1    = !r_s1_v || w_adv2;
    assign w_hs      = r_s2_v && i_ready;
    assign o_ready   = w_adv1 && !i_rst;
    assign o_valid   = r_s2_v;
    assign o_data    = r_s2_data;
    assign o_sat     = r_s2_sat;
    assign o_sat_cnt = r_cnt;
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        llr_fmt_conv_ch #(.W(W)) u_ch (
            .i_data (r_s1_data[c*W +: W]),
            .i_mode (r_s1_mode),
            .o_data (w_conv[c*W +: W]),
            .o_sat  (w_sat[c])
        );
    end
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_CH; i++) w_pop = w_pop + PW'(r_s2_sat[i]);
        // a clear coinciding with a handshake restarts the count from this beat
        w_sum = (i_sat_clr ? '0 : SW'(r_cnt)) + SW'(w_pop);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_v    <= 1'b0;
            r_s1_data <= '0;
            r_s1_mode <= C2S;
        end else if (w_adv1) begin
            r_s1_v    <= i_valid;
            r_s1_data <= i_data;
            r_s1_mode <= conv_mode_e'(i_mode);
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_v    <= 1'b0;
            r_s2_data <= '0;
            r_s2_sat  <= '0;
        end else if (w_adv2) begin
            r_s2_v    <= r_s1_v;
            r_s2_data <= w_conv;
            r_s2_sat  <= w_sat;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) r_cnt <= '0;
        else if (w_hs) r_cnt <= w_sum > CNT_MAX ? {CNT_W{1'b1}} : CNT_W'(w_sum);
        else if (i_sat_clr) r_cnt <= '0;
    end
endmodule
